// File: rtl/mem_wb_stage_pkg.sv
// Shared widths, load funct3 encodings, FSM state type and small sign-extension
// helpers for the MEM->WB writeback stage.
package mem_wb_stage_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;

  localparam logic [REG_W-1:0]  ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] REG_ZERO  = '0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

  // Everything about an accepted load that must survive until its data returns.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
  } load_ctx_t;

  function automatic logic [REG_W-1:0] sext8(input logic signed [7:0] b);
    return REG_W'(b);
  endfunction

  function automatic logic [REG_W-1:0] sext16(input logic signed [15:0] h);
    return REG_W'(h);
  endfunction

  function automatic logic [REG_W-1:0] zext8(input logic [7:0] b);
    return REG_W'(b);
  endfunction

  function automatic logic [REG_W-1:0] zext16(input logic [15:0] h);
    return REG_W'(h);
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational little-endian load alignment with sign/zero extension;
// flags funct3 codes that are not RV32I loads.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [REG_W-1:0] rdata_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  output logic [REG_W-1:0] data_o,
  output logic             legal_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword selection uses only addr_lo[1]; misaligned halves never reach here.
  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o  = ZERO_WORD;
    legal_o = 1'b1;
    case (funct3_i)
      F3_LB:   data_o = sext8(byte_sel);
      F3_LH:   data_o = sext16(half_sel);
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = zext8(byte_sel);
      F3_LHU:  data_o = zext16(half_sel);
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: registers ALU/CSR results, waits for load data from the
// data-memory handshake, and drives a registered one-cycle regfile write.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [REG_W-1:0]  in_wdata,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic [REG_W-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic              stall_req,
  output logic              busy,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [REG_W-1:0]  wb_wdata
);

  wb_state_e         state_q;
  load_ctx_t         ctx_q;
  logic              wb_we_q;
  logic [ADDR_W-1:0] wb_waddr_q;
  logic [REG_W-1:0]  wb_wdata_q;

  logic              accept;
  logic [REG_W-1:0]  load_data;
  logic              load_legal;

  mem_wb_stage_load_align u_align (
    .rdata_i   (mem_rdata),
    .funct3_i  (ctx_q.funct3),
    .addr_lo_i (ctx_q.addr_lo),
    .data_o    (load_data),
    .legal_o   (load_legal)
  );

  assign accept = in_valid & ~stall_i & ~flush_i & (state_q == WB_IDLE);

  // Completion in WAIT deliberately ignores stall_i; only flush or reset cancel it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= REG_ZERO;
      wb_wdata_q <= ZERO_WORD;
    end else if (flush_i) begin
      state_q <= WB_IDLE;
      wb_we_q <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (accept && in_is_load) begin
            state_q       <= WB_WAIT;
            ctx_q.we      <= in_we;
            ctx_q.waddr   <= in_waddr;
            ctx_q.funct3  <= in_funct3;
            ctx_q.addr_lo <= in_addr_lo;
            wb_we_q       <= 1'b0;
          end else if (accept) begin
            wb_we_q    <= in_we & (in_waddr != REG_ZERO);
            wb_waddr_q <= in_waddr;
            wb_wdata_q <= in_wdata;
          end else begin
            wb_we_q <= 1'b0;
          end
        end
        WB_WAIT: begin
          if (mem_ready) begin
            state_q    <= WB_IDLE;
            wb_we_q    <= ctx_q.we & (ctx_q.waddr != REG_ZERO) & load_legal;
            wb_waddr_q <= ctx_q.waddr;
            wb_wdata_q <= load_data;
          end else begin
            wb_we_q <= 1'b0;
          end
        end
        default: begin
          state_q <= WB_IDLE;
          wb_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req = (state_q == WB_WAIT);
  assign busy      = (state_q == WB_WAIT);
  assign wb_we     = wb_we_q;
  assign wb_waddr  = wb_waddr_q;
  assign wb_wdata  = wb_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load-alignment table,
// hand-written multi-cycle sequences, and randomized traffic against a model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        in_valid;
  logic        in_we;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_req;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .in_valid   (in_valid),
    .in_we      (in_we),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall_req  (stall_req),
    .busy       (busy),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rd;
    logic [31:0] exp;
    logic        exp_we;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result from byte/halfword arithmetic; bit 32 = legal.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] rd);
    int v;
    int sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = 8 * int'(lo);
        v  = int'((rd >> sh) & 32'hFF);
        if (f3 == 3'd0 && v > 127) v = v - 256;
        return {1'b1, 32'(v)};
      end
      3'd1, 3'd5: begin
        sh = 16 * (int'(lo) / 2);
        v  = int'((rd >> sh) & 32'hFFFF);
        if (f3 == 3'd1 && v > 32767) v = v - 65536;
        return {1'b1, 32'(v)};
      end
      3'd2:    return {1'b1, rd};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; in_valid = 1'b0; in_we = 1'b0;
    in_waddr = 5'd0; in_wdata = 32'h0; in_is_load = 1'b0; in_funct3 = 3'd0;
    in_addr_lo = 2'd0; mem_rdata = 32'h0; mem_ready = 1'b0;
  endtask

  task automatic run_alu(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input string tag);
    in_valid = 1'b1; in_is_load = 1'b0; in_we = we; in_waddr = wa; in_wdata = wd;
    tick();
    in_valid = 1'b0;
    chk({tag, "_we"}, 32'(wb_we), 32'(we & (wa != 5'd0)));
    chk({tag, "_waddr"}, 32'(wb_waddr), 32'(wa));
    chk({tag, "_wdata"}, wb_wdata, wd);
    tick();
    chk({tag, "_bubble"}, 32'(wb_we), 32'h0);
  endtask

  // stall_mode: 0 none, 1 random, 2 always asserted while waiting.
  task automatic run_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd,
                          input logic [4:0] wa, input logic we, input int lat,
                          input int stall_mode, input logic [31:0] exp_data,
                          input logic exp_we, input string tag);
    int stall_cnt = 0;
    in_valid = 1'b1; in_is_load = 1'b1; in_we = we; in_waddr = wa; in_funct3 = f3;
    in_addr_lo = lo; in_wdata = $urandom;
    tick();
    chk({tag, "_accept_we"}, 32'(wb_we), 32'h0);
    for (int c = 0; c < lat; c++) begin
      if (stall_req) stall_cnt++;
      chk({tag, "_busy"}, 32'(busy), 32'(stall_req));
      in_valid   = (stall_mode != 0) ? 1'($urandom_range(1)) : 1'b0;
      in_is_load = 1'($urandom_range(1));
      in_waddr   = 5'($urandom);
      in_we      = 1'b1;
      stall_i    = (stall_mode == 2) ? 1'b1 :
                   (stall_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      mem_ready  = (c == lat - 1);
      mem_rdata  = mem_ready ? rd : $urandom;
      tick();
      if (c < lat - 1) chk({tag, "_wait_we"}, 32'(wb_we), 32'h0);
    end
    mem_ready = 1'b0; stall_i = 1'b0; in_valid = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
    chk({tag, "_we"}, 32'(wb_we), 32'(exp_we));
    chk({tag, "_wdata"}, wb_wdata, exp_data);
    if (exp_we) chk({tag, "_waddr"}, 32'(wb_waddr), 32'(wa));
    chk({tag, "_idle"}, 32'(stall_req), 32'h0);
    tick();
    chk({tag, "_single"}, 32'(wb_we), 32'h0);
  endtask

  initial begin
    logic [32:0] r;
    idle_inputs();

    tbl[0]  = '{3'b000, 2'd3, 32'h80123456, 32'hFFFFFF80, 1'b1};
    tbl[1]  = '{3'b101, 2'd2, 32'h80123456, 32'h00008012, 1'b1};
    tbl[2]  = '{3'b000, 2'd0, 32'h80123456, 32'h00000056, 1'b1};
    tbl[3]  = '{3'b000, 2'd2, 32'h80123456, 32'h00000012, 1'b1};
    tbl[4]  = '{3'b001, 2'd1, 32'h80123456, 32'h00003456, 1'b1};
    tbl[5]  = '{3'b001, 2'd2, 32'h80123456, 32'hFFFF8012, 1'b1};
    tbl[6]  = '{3'b010, 2'd1, 32'h80123456, 32'h80123456, 1'b1};
    tbl[7]  = '{3'b100, 2'd3, 32'h80123456, 32'h00000080, 1'b1};
    tbl[8]  = '{3'b100, 2'd1, 32'h00FF00A5, 32'h00000000, 1'b1};
    tbl[9]  = '{3'b011, 2'd0, 32'h80123456, 32'h00000000, 1'b0};
    tbl[10] = '{3'b110, 2'd0, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[11] = '{3'b111, 2'd2, 32'hFFFFFFFF, 32'h00000000, 1'b0};

    // Reset with live-looking inputs
    rst = 1'b1; in_valid = 1'b1; in_is_load = 1'b1; in_we = 1'b1; in_waddr = 5'd3;
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_we", 32'(wb_we), 32'h0);
      chk("reset_wdata", wb_wdata, 32'h0);
      chk("reset_stall", 32'(stall_req), 32'h0);
    end
    idle_inputs();
    tick();

    run_alu(1'b1, 5'd5, 32'hDEADBEEF, "alu");
    run_alu(1'b1, 5'd0, 32'h12345678, "alu_x0");
    run_alu(1'b0, 5'd9, 32'h0BADF00D, "alu_nowe");

    run_load(3'b000, 2'd3, 32'h80123456, 5'd10, 1'b1, 3, 0, 32'hFFFFFF80, 1'b1, "lb_late3");
    for (int i = 0; i < 12; i++)
      run_load(tbl[i].f3, tbl[i].lo, tbl[i].rd, 5'(i + 1), 1'b1, 1 + (i % 3), 0,
               tbl[i].exp, tbl[i].exp_we, $sformatf("tbl%0d", i));
    run_load(3'b010, 2'd0, 32'hCAFEBABE, 5'd0, 1'b1, 2, 0, 32'hCAFEBABE, 1'b0, "lw_x0");
    run_load(3'b010, 2'd0, 32'h13572468, 5'd12, 1'b1, 3, 2, 32'h13572468, 1'b1, "lw_stalled");

    // Flush coincident with mem_ready drops the load
    in_valid = 1'b1; in_is_load = 1'b1; in_we = 1'b1; in_waddr = 5'd14; in_funct3 = 3'b010;
    tick();
    in_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h11111111; flush_i = 1'b1;
    tick();
    chk("flush_we", 32'(wb_we), 32'h0);
    chk("flush_idle", 32'(stall_req), 32'h0);
    flush_i = 1'b0;
    tick();
    chk("flush_late_ready", 32'(wb_we), 32'h0);
    mem_ready = 1'b0;
    run_alu(1'b1, 5'd7, 32'h00001234, "after_flush");

    // Reset mid-load, then a late mem_ready
    in_valid = 1'b1; in_is_load = 1'b1; in_we = 1'b1; in_waddr = 5'd15; in_funct3 = 3'b010;
    tick();
    in_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h22222222; rst = 1'b1;
    tick();
    chk("rstmid_we", 32'(wb_we), 32'h0);
    chk("rstmid_wdata", wb_wdata, 32'h0);
    chk("rstmid_idle", 32'(stall_req), 32'h0);
    rst = 1'b0;
    tick();
    chk("rstmid_late_ready", 32'(wb_we), 32'h0);
    mem_ready = 1'b0;
    run_alu(1'b1, 5'd8, 32'h00005678, "after_rst");

    // Global stall holds off acceptance; exactly one write on release
    in_valid = 1'b1; in_is_load = 1'b0; in_we = 1'b1; in_waddr = 5'd9; in_wdata = 32'hAAAA5555;
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_hold_we", 32'(wb_we), 32'h0);
    end
    stall_i = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("stall_release_we", 32'(wb_we), 32'h1);
    chk("stall_release_wdata", wb_wdata, 32'hAAAA5555);
    tick();
    chk("stall_no_dup", 32'(wb_we), 32'h0);

    // Instruction arriving with mem_ready waits one cycle
    in_valid = 1'b1; in_is_load = 1'b1; in_we = 1'b1; in_waddr = 5'd4; in_funct3 = 3'b010;
    tick();
    in_is_load = 1'b0; in_waddr = 5'd6; in_wdata = 32'h00000055;
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    tick();
    mem_ready = 1'b0;
    chk("b2b_load_we", 32'(wb_we), 32'h1);
    chk("b2b_load_waddr", 32'(wb_waddr), 32'd4);
    chk("b2b_load_wdata", wb_wdata, 32'h11223344);
    tick();
    in_valid = 1'b0;
    chk("b2b_alu_we", 32'(wb_we), 32'h1);
    chk("b2b_alu_waddr", 32'(wb_waddr), 32'd6);
    chk("b2b_alu_wdata", wb_wdata, 32'h00000055);
    tick();
    chk("b2b_bubble", 32'(wb_we), 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] rd;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [4:0]  wa;
      logic        we;
      rd = $urandom; f3 = 3'($urandom); lo = 2'($urandom); wa = 5'($urandom);
      we = ($urandom_range(7) != 0);
      if ($urandom_range(1) == 0) begin
        run_alu(we, wa, rd, "rnd_alu");
      end else begin
        r = ref_load(f3, lo, rd);
        run_load(f3, lo, rd, wa, we, 1 + $urandom_range(3), 1, r[31:0],
                 r[32] & we & (wa != 5'd0), "rnd_load");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
